// File: rtl/reg_op_pkg.sv
// Shared types for the register-operation sequencer: operation codes, FSM states and latency.
package reg_op_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpAnd  = 3'd2,
        OpOr   = 3'd3,
        OpXor  = 3'd4,
        OpSlt  = 3'd5,
        OpPass = 3'd6,
        OpCmp  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StExec = 2'd2,
        StWb   = 2'd3
    } state_e;

    localparam int unsigned OP_LATENCY = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational M-bit ALU: result plus carry (ADD) or unsigned borrow (SUB/CMP).
module alu_core
    import reg_op_pkg::*;
#(
    parameter int unsigned M = 4
) (
    input  op_e          op,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] y,
    output logic         c
);

    logic [M:0] sum;
    logic [M:0] diff;

    // The extra top bit of diff is the borrow, i.e. a < b unsigned.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y = '0;
        c = 1'b0;
        unique case (op)
            OpAdd: begin
                y = sum[M-1:0];
                c = sum[M];
            end
            OpSub, OpCmp: begin
                y = diff[M-1:0];
                c = diff[M];
            end
            OpAnd:  y = a & b;
            OpOr:   y = a | b;
            OpXor:  y = a ^ b;
            OpSlt:  y = {{(M-1){1'b0}}, diff[M]};
            OpPass: y = a;
            default: begin
                y = '0;
                c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_op_sequencer.sv
// Four-cycle IDLE/READ/EXEC/WB sequencer driving a 2R1W register RAM around an ALU.
module reg_op_sequencer
    import reg_op_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned M = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [2:0]   op_code,
    input  logic [N-1:0] op_rs1,
    input  logic [N-1:0] op_rs2,
    input  logic [N-1:0] op_rd,
    output logic [N-1:0] a1,
    output logic [N-1:0] a2,
    input  logic [M-1:0] d1,
    input  logic [M-1:0] d2,
    output logic [N-1:0] a3,
    output logic [M-1:0] d3,
    output logic         we3,
    output logic         done,
    output logic [M-1:0] result,
    output logic         flag_z,
    output logic         flag_c
);

    state_e       state_q, state_d;
    op_e          op_q;
    logic [N-1:0] rs1_q, rs2_q, rd_q;
    logic [M-1:0] opa_q, opb_q;
    logic [M-1:0] result_q;
    logic         flag_z_q, flag_c_q;
    logic         we3_q, done_q;
    logic         accept;
    logic [M-1:0] alu_y;
    logic         alu_c;

    alu_core #(
        .M(M)
    ) u_alu (
        .op(op_q),
        .a (opa_q),
        .b (opb_q),
        .y (alu_y),
        .c (alu_c)
    );

    assign accept = (state_q == StIdle) && op_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (op_valid) state_d = StRead;
            StRead:  state_d = StExec;
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= OpAdd;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            we3_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op_e'(op_code);
                rs1_q <= op_rs1;
                rs2_q <= op_rs2;
                rd_q  <= op_rd;
            end
            if (state_q == StRead) begin
                opa_q <= d1;
                opb_q <= d2;
            end
            if (state_q == StExec) begin
                result_q <= alu_y;
                flag_z_q <= (alu_y == '0);
                flag_c_q <= alu_c;
            end
            // Write strobe and done are registered so they are high exactly during WB.
            we3_q  <= (state_q == StExec) && (op_q != OpCmp);
            done_q <= (state_q == StExec);
        end
    end

    assign op_ready = (state_q == StIdle);
    assign a1       = rs1_q;
    assign a2       = rs2_q;
    assign a3       = rd_q;
    assign d3       = result_q;
    assign we3      = we3_q;
    assign done     = done_q;
    assign result   = result_q;
    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;

endmodule

// File: doc/reg_op_sequencer.md
# reg_op_sequencer

Multicycle register-to-register operation sequencer that sits directly upstream of the 3-port register RAM (2 read ports, 1 write port). It accepts one operation at a time over a valid/ready handshake and drives the RAM read addresses `a1`/`a2`. It latches the returned data `d1`/`d2`, computes an M-bit ALU result, and writes it back through `a3`/`d3`/`we3`. One operation completes every 4 cycles; the block never overlaps operations.

## Interface
- `N`, default 2: register address width; the register file holds 2**N entries.
- `M`, default 4: data width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `op_valid`  in  1  an operation is offered this cycle.
- `op_ready`  out  1  sequencer can accept an operation; high only in IDLE.
- `op_code`  in  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (unsigned), 6 PASS (rs1), 7 CMP (SUB, flags only, no write).
- `op_rs1`, `op_rs2`, `op_rd`  in  N  source and destination register addresses.
- `a1`, `a2`  out  N  register RAM read addresses.
- `d1`, `d2`  in  M  register RAM read data (combinational from `a1`/`a2`).
- `a3`  out  N  register RAM write address.
- `d3`  out  M  register RAM write data.
- `we3`  out  1  register RAM write enable.
- `done`  out  1  one-cycle pulse when an operation retires.
- `result`  out  M  last computed result; holds until the next EXEC.
- `flag_z`, `flag_c`  out  1  zero and carry/borrow of the last result; hold until the next EXEC.

## Operation
- States: IDLE, READ, EXEC, WB.
- IDLE: `op_ready`=1. On `op_valid`=1, latch `op_code`, `op_rs1`, `op_rs2`, `op_rd` and go to READ. Otherwise stay in IDLE.
- READ: drive `a1`=rs1 and `a2`=rs2. Capture `d1`/`d2` into operand registers at the end of the cycle, then go to EXEC.
- EXEC: compute the result from the latched operands. Register `result`, `flag_z` and `flag_c`, then go to WB.
- WB: `done`=1. For op_code 0–6: `we3`=1, `a3`=rd, `d3`=result. For CMP: `we3`=0. Go to IDLE.
- Arithmetic is modulo 2**M.
  - ADD: `flag_c` = carry out of bit M-1.
  - SUB/CMP: `flag_c` = 1 when rs1 < rs2 (unsigned borrow).
  - AND, OR, XOR, SLT, PASS: `flag_c` = 0.
- SLT result is 1 or 0, zero-extended to M bits.
- `flag_z` = (result == 0).
- Outside READ, `a1`/`a2` hold the latched rs1/rs2. Outside WB, `a3` holds the latched rd and `d3` holds `result`. `we3` is 0 outside WB.
- rd equal to rs1 or rs2 is legal: operands are captured in READ, before the write in WB.
- `op_valid` while not in IDLE is ignored; the operation is not queued.

## Timing
- Reset values: state IDLE; `op_ready`=1; `we3`=0; `done`=0; `a1`, `a2`, `a3`, `d3`, `result`, `flag_z`, `flag_c` all 0; operand registers 0.
- Handshake transfer happens in cycle T (`op_valid` & `op_ready`). READ is T+1, EXEC is T+2, WB is T+3 (`we3`/`done` high). RAM is updated at the end of T+3.
- `op_ready` returns to 1 at T+4. Back-to-back operations therefore issue every 4 cycles.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). No write is issued, even if reset lands in WB before the clock edge.
- All outputs are registered, except that `op_ready` is decoded from state.

## Structure
- Shared package `reg_op_pkg`:
  - `op_e` enum (3-bit, values as above).
  - `state_e` enum (IDLE, READ, EXEC, WB).
  - Localparam `OP_LATENCY` = 4.
- Sub-module `alu_core` (combinational): inputs op, a, b (M); outputs y (M), c.
- The testbench instantiates `reg_op_sequencer` together with the register RAM, wired `a1`/`a2`/`a3`/`d1`/`d2`/`d3`/`we3`.

## Test plan
All scenarios use N=2, M=4.
- Reset: hold `rst_n`=0 with `op_valid`=1 → `op_ready`=1, `we3`=0, `done`=0, `result`=0 throughout; no RAM change.
- ADD with carry: preload r0=9, r1=8; ADD rd=2 → at T+3 `we3`=1, `a3`=2, `d3`=1, `flag_c`=1, `flag_z`=0; r2 reads 1 afterwards.
- SUB to zero and CMP:
  - preload r1=5, r3=5; SUB rd=1 → r1=0, `flag_z`=1, `flag_c`=0.
  - CMP r0=3, r1=7 → `we3` stays 0 for the whole operation, `flag_c`=1, `result`=12, `done` pulses at T+3.
- In-place update: r2=6; ADD rs1=2, rs2=2, rd=2 → r2=12. Then `op_valid` held high → next transfer exactly 4 cycles after the first, `op_ready`=0 for T+1..T+3.
- Logic ops: r0=0xA, r1=0x6 → AND 0x2, OR 0xE, XOR 0xC, SLT 0, PASS 0xA; `flag_c`=0 each time.
- Reset during WB: drop `rst_n` while in WB, before the edge → `we3` falls immediately, destination register unchanged, state IDLE after release.
